ps_requester: RTL and testbench

PS_REQUESTER -- requirements
Module: ps_requester

---
 rtl/ps_requester_if.sv | 46 ++++
 rtl/ps_requester.sv | 137 +++++++++++++
 tb/tb_ps_requester.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps_requester_if.sv
// Requester bundle: job enqueue, selector request/grant, transfer beats.
// master = requester side, slave = job source / selector / sink side.
interface ps_requester_if;
  logic [3:0] job_valid;
  logic [3:0] job_ready;
  logic [3:0] req;
  logic       en;
  logic [3:0] gnt;
  logic       req_up;
  logic       xfer_valid;
  logic [1:0] xfer_ch;
  logic [1:0] xfer_beat;
  logic       xfer_last;
  logic       busy;
  logic       err;

  modport master (
    input  job_valid,
    input  gnt,
    input  req_up,
    output job_ready,
    output req,
    output en,
    output xfer_valid,
    output xfer_ch,
    output xfer_beat,
    output xfer_last,
    output busy,
    output err
  );

  modport slave (
    output job_valid,
    output gnt,
    output req_up,
    input  job_ready,
    input  req,
    input  en,
    input  xfer_valid,
    input  xfer_ch,
    input  xfer_beat,
    input  xfer_last,
    input  busy,
    input  err
  );
endinterface

// File: rtl/ps_requester.sv
// Per-channel job counters feeding an external priority selector; runs
// BEATS-beat transfers for granted channels. Ports: clk, rst, bus (master).
module ps_requester #(
  parameter int BEATS = 4,
  parameter int CNT_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  ps_requester_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [1:0]       LAST    = 2'(BEATS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pend_q [4];
  logic [1:0]       beat_q, beat_d;
  logic [1:0]       ch_q, ch_d;
  logic             err_q, err_set;

  logic [3:0] req;
  logic [3:0] full;
  logic [3:0] inc;
  logic [3:0] dec;
  logic [3:0] exp_gnt;
  logic [1:0] exp_idx;

  always_comb begin
    req  = '0;
    full = '0;
    for (int i = 0; i < 4; i++) begin
      req[i]  = (pend_q[i] != '0);
      full[i] = (pend_q[i] == CNT_MAX);
    end
  end

  // The only grant we accept: highest-index requesting channel.
  always_comb begin
    exp_gnt = '0;
    priority case (1'b1)
      req[3]:  exp_gnt = 4'b1000;
      req[2]:  exp_gnt = 4'b0100;
      req[1]:  exp_gnt = 4'b0010;
      req[0]:  exp_gnt = 4'b0001;
      default: exp_gnt = '0;
    endcase
  end

  always_comb begin
    exp_idx = 2'd0;
    unique case (1'b1)
      exp_gnt[3]: exp_idx = 2'd3;
      exp_gnt[2]: exp_idx = 2'd2;
      exp_gnt[1]: exp_idx = 2'd1;
      exp_gnt[0]: exp_idx = 2'd0;
      default:    exp_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    ch_d    = ch_q;
    dec     = '0;
    err_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) state_d = ARB;
      end
      ARB: begin
        // A zero grant means the selector has not caught up yet.
        if (bus.gnt != '0) begin
          if (bus.req_up != (|req) || bus.gnt != exp_gnt) begin
            err_set = 1'b1;
            state_d = IDLE;
          end else begin
            dec     = exp_gnt;
            ch_d    = exp_idx;
            beat_d  = 2'd0;
            state_d = XFER;
          end
        end
      end
      XFER: begin
        if (beat_q == LAST) begin
          beat_d  = 2'd0;
          state_d = (|req) ? ARB : IDLE;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full channel frees a slot in its own grant cycle.
  assign bus.job_ready = ~full | dec;
  assign inc           = bus.job_valid & bus.job_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      ch_q    <= 2'd0;
      err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) pend_q[i] <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ch_q    <= ch_d;
      if (err_set) err_q <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (inc[i] && !dec[i])
          pend_q[i] <= pend_q[i] + CNT_ONE;
        else if (dec[i] && !inc[i])
          pend_q[i] <= pend_q[i] - CNT_ONE;
      end
    end
  end

  assign bus.req        = req;
  assign bus.en         = (state_q == ARB);
  assign bus.xfer_valid = (state_q == XFER);
  assign bus.xfer_ch    = ch_q;
  assign bus.xfer_beat  = beat_q;
  assign bus.xfer_last  = (state_q == XFER) && (beat_q == LAST);
  assign bus.busy       = (state_q == ARB) || (state_q == XFER);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_ps_requester.sv
// Directed bench for ps_requester with a behavioural priority selector
// that can be overridden to inject bad grants.
module tb_ps_requester;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic       sel_auto  = 1'b1;
  logic [3:0] gnt_force = '0;
  logic       up_force  = 1'b0;

  ps_requester_if bus ();

  ps_requester #(
    .BEATS(4),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.gnt    = gnt_force;
    bus.req_up = up_force;
    if (sel_auto) begin
      bus.gnt    = '0;
      bus.req_up = bus.en & (|bus.req);
      if (bus.en) begin
        if (bus.req[3])      bus.gnt = 4'b1000;
        else if (bus.req[2]) bus.gnt = 4'b0100;
        else if (bus.req[1]) bus.gnt = 4'b0010;
        else if (bus.req[0]) bus.gnt = 4'b0001;
      end
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_xfer(output logic [1:0] ch, output bit ok);
    ok = 1'b0;
    ch = 2'd0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (bus.xfer_valid && bus.xfer_beat == 2'd0) begin
        ch = bus.xfer_ch;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset;
    bus.job_valid = '0;
    sel_auto      = 1'b1;
    gnt_force     = '0;
    up_force      = 1'b0;
    rst           = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    bus.job_valid = '0;
    rst = 1'b1;
    tick;
    checks++;
    if (bus.req !== 4'b0000) begin
      errors++; $display("FAIL rst_req: got %b want 0000", bus.req);
    end
    checks++;
    if (bus.en !== 1'b0) begin
      errors++; $display("FAIL rst_en: got %b want 0", bus.en);
    end
    checks++;
    if (bus.xfer_valid !== 1'b0 || bus.xfer_last !== 1'b0) begin
      errors++;
      $display("FAIL rst_xfer: got v=%b l=%b want 0 0",
               bus.xfer_valid, bus.xfer_last);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_err: got %b %b want 0 0", bus.busy, bus.err);
    end
    checks++;
    if (bus.job_ready !== 4'b1111) begin
      errors++; $display("FAIL rst_ready: got %b want 1111", bus.job_ready);
    end
    checks++;
    if (bus.xfer_ch !== 2'd0 || bus.xfer_beat !== 2'd0) begin
      errors++;
      $display("FAIL rst_ch_beat: got %0d %0d want 0 0",
               bus.xfer_ch, bus.xfer_beat);
    end
    rst = 1'b0;
    tick;
    tick;
    checks++;
    if (bus.busy !== 1'b0 || bus.req !== 4'b0000) begin
      errors++;
      $display("FAIL post_rst_idle: got busy=%b req=%b want 0 0000",
               bus.busy, bus.req);
    end
  endtask

  task automatic test_single;
    logic exp_last;
    bus.job_valid = 4'b0100;
    tick;
    bus.job_valid = '0;
    checks++;
    if (bus.req !== 4'b0100 || bus.en !== 1'b0) begin
      errors++;
      $display("FAIL single_n1: got req=%b en=%b want 0100 0",
               bus.req, bus.en);
    end
    tick;
    checks++;
    if (bus.en !== 1'b1 || bus.xfer_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_en: got en=%b v=%b want 1 0",
               bus.en, bus.xfer_valid);
    end
    for (int b = 0; b < 4; b++) begin
      tick;
      exp_last = (b == 3);
      checks++;
      if (bus.xfer_valid !== 1'b1 || bus.xfer_ch !== 2'd2 ||
          bus.xfer_beat !== 2'(b) || bus.xfer_last !== exp_last) begin
        errors++;
        $display("FAIL single_beat%0d: got v=%b ch=%0d b=%0d l=%b want 1 2 %0d %b",
                 b, bus.xfer_valid, bus.xfer_ch, bus.xfer_beat,
                 bus.xfer_last, b, exp_last);
      end
    end
    tick;
    checks++;
    if (bus.busy !== 1'b0 || bus.req !== 4'b0000 ||
        bus.xfer_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got busy=%b req=%b v=%b want 0 0000 0",
               bus.busy, bus.req, bus.xfer_valid);
    end
  endtask

  task automatic test_two_channels;
    logic [1:0] ch;
    bit ok;
    bus.job_valid = 4'b1001;
    tick;
    bus.job_valid = '0;
    wait_xfer(ch, ok);
    checks++;
    if (!ok || ch !== 2'd3) begin
      errors++; $display("FAIL two_first: got ok=%0d ch=%0d want 1 3", ok, ch);
    end
    repeat (3) tick;
    checks++;
    if (bus.xfer_last !== 1'b1) begin
      errors++; $display("FAIL two_last: got %b want 1", bus.xfer_last);
    end
    tick;
    checks++;
    if (bus.en !== 1'b1 || bus.xfer_valid !== 1'b0) begin
      errors++;
      $display("FAIL two_rearb: got en=%b v=%b want 1 0",
               bus.en, bus.xfer_valid);
    end
    tick;
    checks++;
    if (bus.xfer_valid !== 1'b1 || bus.xfer_ch !== 2'd0) begin
      errors++;
      $display("FAIL two_second: got v=%b ch=%0d want 1 0",
               bus.xfer_valid, bus.xfer_ch);
    end
    repeat (4) tick;
    checks++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL two_done: got busy=%b err=%b want 0 0",
               bus.busy, bus.err);
    end
  endtask

  task automatic test_fill;
    logic [3:0] exp_rdy;
    int n;
    sel_auto  = 1'b0;
    gnt_force = '0;
    up_force  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.job_valid = 4'b0010;
      tick;
      exp_rdy = (k < 2) ? 4'b1111 : 4'b1101;
      checks++;
      if (bus.job_ready !== exp_rdy) begin
        errors++;
        $display("FAIL fill_ready%0d: got %b want %b",
                 k, bus.job_ready, exp_rdy);
      end
    end
    bus.job_valid = '0;
    checks++;
    if (bus.req !== 4'b0010 || bus.en !== 1'b1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL fill_stall: got req=%b en=%b err=%b want 0010 1 0",
               bus.req, bus.en, bus.err);
    end
    sel_auto = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (bus.xfer_valid && bus.xfer_last && bus.xfer_ch == 2'd1) n++;
    end
    checks++;
    if (n != 3 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_xfers: got %0d busy=%b want 3 0", n, bus.busy);
    end
  endtask

  task automatic test_grant_enqueue;
    int n;
    sel_auto = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.job_valid = 4'b0010;
      tick;
    end
    checks++;
    if (bus.job_ready[1] !== 1'b0 || bus.en !== 1'b1) begin
      errors++;
      $display("FAIL ge_full: got rdy1=%b en=%b want 0 1",
               bus.job_ready[1], bus.en);
    end
    sel_auto = 1'b1;
    #1;
    checks++;
    if (bus.job_ready[1] !== 1'b1) begin
      errors++; $display("FAIL ge_ready: got %b want 1", bus.job_ready[1]);
    end
    tick;
    bus.job_valid = '0;
    checks++;
    if (bus.xfer_valid !== 1'b1 || bus.job_ready[1] !== 1'b0 ||
        bus.req[1] !== 1'b1) begin
      errors++;
      $display("FAIL ge_after: got v=%b rdy1=%b req1=%b want 1 0 1",
               bus.xfer_valid, bus.job_ready[1], bus.req[1]);
    end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.xfer_valid && bus.xfer_last && bus.xfer_ch == 2'd1) n++;
      tick;
    end
    checks++;
    if (n != 4 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ge_xfers: got %0d busy=%b want 4 0", n, bus.busy);
    end
  endtask

  task automatic test_multi_hot;
    sel_auto = 1'b0;
    bus.job_valid = 4'b1100;
    tick;
    bus.job_valid = '0;
    tick;
    checks++;
    if (bus.en !== 1'b1 || bus.req !== 4'b1100) begin
      errors++;
      $display("FAIL mh_arb: got en=%b req=%b want 1 1100", bus.en, bus.req);
    end
    gnt_force = 4'b1100;
    up_force  = 1'b1;
    tick;
    gnt_force = '0;
    up_force  = 1'b0;
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.req !== 4'b1100) begin
      errors++;
      $display("FAIL mh_err: got err=%b busy=%b req=%b want 1 0 1100",
               bus.err, bus.busy, bus.req);
    end
    sel_auto = 1'b1;
    repeat (30) tick;
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.req !== 4'b0000) begin
      errors++;
      $display("FAIL mh_sticky: got err=%b busy=%b req=%b want 1 0 0000",
               bus.err, bus.busy, bus.req);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL mh_clear: got %b want 0", bus.err);
    end
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_wrong_prio;
    sel_auto = 1'b0;
    bus.job_valid = 4'b1010;
    tick;
    bus.job_valid = '0;
    tick;
    gnt_force = 4'b0010;
    up_force  = 1'b1;
    tick;
    gnt_force = '0;
    up_force  = 1'b0;
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.req !== 4'b1010) begin
      errors++;
      $display("FAIL prio_err: got err=%b busy=%b req=%b want 1 0 1010",
               bus.err, bus.busy, bus.req);
    end
    do_reset();
    checks++;
    if (bus.err !== 1'b0 || bus.req !== 4'b0000) begin
      errors++;
      $display("FAIL prio_rst: got err=%b req=%b want 0 0000",
               bus.err, bus.req);
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] ch;
    bit ok;
    int n;
    bus.job_valid = 4'b0111;
    tick;
    bus.job_valid = '0;
    wait_xfer(ch, ok);
    checks++;
    if (!ok || ch !== 2'd2) begin
      errors++; $display("FAIL mid_first: got ok=%0d ch=%0d want 1 2", ok, ch);
    end
    tick;
    tick;
    checks++;
    if (bus.xfer_beat !== 2'd2 || bus.req !== 4'b0011) begin
      errors++;
      $display("FAIL mid_beat2: got beat=%0d req=%b want 2 0011",
               bus.xfer_beat, bus.req);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.xfer_valid !== 1'b0 || bus.req !== 4'b0000 ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_abort: got v=%b req=%b busy=%b want 0 0000 0",
               bus.xfer_valid, bus.req, bus.busy);
    end
    tick;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (bus.xfer_valid) n++;
    end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL mid_after: got %0d beats want 0", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.job_valid = '0;
    test_reset();
    test_single();
    test_two_channels();
    test_fill();
    test_grant_enqueue();
    test_multi_hot();
    test_wrong_prio();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
